// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, control-word field and encoding definitions for the main decoder
package ctrl_pkg;

  localparam int SIG_W = 14;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ALUI_LO = 6'h08;
  localparam logic [5:0] OP_ALUI_HI = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // Bit positions inside the control word
  localparam int SIG_MEMBYTE   = 13;
  localparam int SIG_ALUOP     = 12;
  localparam int SIG_SA        = 11;
  localparam int SIG_SB_HI     = 10;
  localparam int SIG_SB_LO     = 9;
  localparam int SIG_REGDST_HI = 8;
  localparam int SIG_REGDST_LO = 7;
  localparam int SIG_MEM2REG   = 6;
  localparam int SIG_REGW      = 5;
  localparam int SIG_MEMR      = 4;
  localparam int SIG_MEMW      = 3;
  localparam int SIG_PC_S      = 2;
  localparam int SIG_PCWC      = 1;
  localparam int SIG_PCW       = 0;

  typedef enum logic [1:0] {
    REGDST_RT  = 2'd0,
    REGDST_RD  = 2'd1,
    REGDST_R31 = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    SB_RB      = 2'd0,
    SB_CONST4  = 2'd1,
    SB_IMM     = 2'd2,
    SB_IMM_SH2 = 2'd3
  } sb_e;

  function automatic logic is_alui(input logic [5:0] op);
    return (op >= OP_ALUI_LO) && (op <= OP_ALUI_HI);
  endfunction

endpackage

// File: rtl/ctrl_if.sv
// rtl/ctrl_if.sv - opcode load port and registered control-word outputs of the decoder
interface ctrl_if;
  logic        op_valid;
  logic [5:0]  op;
  logic [13:0] signal;
  logic        illegal;

  modport master (
    output op_valid,
    output op,
    input  signal,
    input  illegal
  );

  modport slave (
    input  op_valid,
    input  op,
    output signal,
    output illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-word decode; byte loads/stores under CTRL_BYTE_MEM_EN
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]       op,
  output logic [SIG_W-1:0] signal,
  output logic             illegal
);

  // PC_S is reserved and never set; unlisted opcodes fall out as all-zero + illegal
  always_comb begin
    signal  = '0;
    illegal = 1'b0;
    if (is_alui(op)) begin
      signal[SIG_SA]                   = 1'b1;
      signal[SIG_SB_HI:SIG_SB_LO]      = SB_IMM;
      signal[SIG_REGW]                 = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          signal[SIG_ALUOP]                = 1'b1;
          signal[SIG_SA]                   = 1'b1;
          signal[SIG_REGDST_HI:SIG_REGDST_LO] = REGDST_RD;
          signal[SIG_REGW]                 = 1'b1;
        end
        OP_J: begin
          signal[SIG_PCW] = 1'b1;
        end
        OP_JAL: begin
          signal[SIG_REGDST_HI:SIG_REGDST_LO] = REGDST_R31;
          signal[SIG_REGW]                 = 1'b1;
          signal[SIG_PCW]                  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          signal[SIG_SB_HI:SIG_SB_LO] = SB_IMM_SH2;
          signal[SIG_PCWC]            = 1'b1;
        end
        OP_COP0: begin
          signal[SIG_SA]   = 1'b1;
          signal[SIG_REGW] = 1'b1;
        end
        OP_LW: begin
          signal[SIG_SA]              = 1'b1;
          signal[SIG_SB_HI:SIG_SB_LO] = SB_IMM;
          signal[SIG_MEM2REG]         = 1'b1;
          signal[SIG_REGW]            = 1'b1;
          signal[SIG_MEMR]            = 1'b1;
        end
        OP_SW: begin
          signal[SIG_SA]              = 1'b1;
          signal[SIG_SB_HI:SIG_SB_LO] = SB_IMM;
          signal[SIG_MEMW]            = 1'b1;
        end
`ifdef CTRL_BYTE_MEM_EN
        OP_LBU: begin
          signal[SIG_MEMBYTE]         = 1'b1;
          signal[SIG_SA]              = 1'b1;
          signal[SIG_SB_HI:SIG_SB_LO] = SB_IMM;
          signal[SIG_MEM2REG]         = 1'b1;
          signal[SIG_REGW]            = 1'b1;
          signal[SIG_MEMR]            = 1'b1;
        end
        OP_SB: begin
          signal[SIG_MEMBYTE]         = 1'b1;
          signal[SIG_SA]              = 1'b1;
          signal[SIG_SB_HI:SIG_SB_LO] = SB_IMM;
          signal[SIG_MEMW]            = 1'b1;
        end
`endif
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
    signal[SIG_PC_S] = 1'b0;
  end

endmodule

// File: rtl/ctrl.sv
// rtl/ctrl.sv - registered main control decoder; CTRL_BYTE_MEM_EN adds LBU/SB decode
module ctrl
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ctrl_if.slave bus
);

  logic [SIG_W-1:0] dec_signal;
  logic             dec_illegal;
  logic [SIG_W-1:0] signal_q;
  logic             illegal_q;

  ctrl_decode u_decode (
    .op      (bus.op),
    .signal  (dec_signal),
    .illegal (dec_illegal)
  );

  // Async clear drops any held word the moment rst rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signal_q  <= '0;
      illegal_q <= 1'b0;
    end else if (bus.op_valid) begin
      signal_q  <= dec_signal;
      illegal_q <= dec_illegal;
    end
  end

  assign bus.signal  = signal_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_ctrl.sv
// tb/tb_ctrl.sv - scoreboard bench for the registered control decoder
module tb_ctrl;

  typedef struct {
    logic [13:0] sig;
    logic        ill;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ctrl_if bus ();

  ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [13:0] as, input logic ai,
                       input logic [13:0] es, input logic ei);
    checks++;
    if (as !== es || ai !== ei) begin
      errors++;
      $display("FAIL %s: signal=%h illegal=%b expected signal=%h illegal=%b", nm, as, ai, es, ei);
    end
  endtask

  // Each entry describes the outputs expected just after the next rising edge
  task automatic drive(input logic v, input logic [5:0] o, input logic [13:0] es,
                       input logic ei, input string nm);
    exp_t e;
    @(negedge clk);
    bus.op_valid = v;
    bus.op       = o;
    e.sig  = es;
    e.ill  = ei;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, bus.signal, bus.illegal, e.sig, e.ill);
      end
    end
  end

  initial begin
    rst          = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 6'h00;
    #1;
    rst          = 1'b1;
    bus.op       = 6'h23;
    bus.op_valid = 1'b1;
    #1;
    check("reset_async", bus.signal, bus.illegal, 14'h0000, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b1, 6'h23, 14'h0000, 1'b0, "reset_lw");
    drive(1'b0, 6'h23, 14'h0000, 1'b0, "reset_release");
    rst = 1'b0;

    drive(1'b1, 6'h00, 14'h18A0, 1'b0, "rtype");
    drive(1'b1, 6'h02, 14'h0001, 1'b0, "j");
    drive(1'b1, 6'h03, 14'h0121, 1'b0, "jal");
    drive(1'b1, 6'h04, 14'h0602, 1'b0, "beq");
    drive(1'b1, 6'h2B, 14'h0C08, 1'b0, "sw");
    drive(1'b1, 6'h05, 14'h0602, 1'b0, "bne");
    drive(1'b1, 6'h10, 14'h0820, 1'b0, "cop0");

    for (int o = 8; o <= 15; o++) drive(1'b1, 6'(o), 14'h0C20, 1'b0, $sformatf("alui_%0h", o));

    // Mid-cycle reset while 0x0C20 is held
    @(posedge clk);
    #3;
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    #1;
    check("reset_midcycle", bus.signal, bus.illegal, 14'h0000, 1'b0);
    drive(1'b0, 6'h0F, 14'h0000, 1'b0, "reset_mid_hold");
    rst = 1'b0;
    drive(1'b0, 6'h0F, 14'h0000, 1'b0, "post_reset_idle");

    drive(1'b1, 6'h3F, 14'h0000, 1'b1, "illegal_3f");
    drive(1'b0, 6'h00, 14'h0000, 1'b1, "illegal_hold");
    drive(1'b1, 6'h01, 14'h0000, 1'b1, "illegal_01");
    drive(1'b1, 6'h07, 14'h0000, 1'b1, "illegal_07");
    drive(1'b1, 6'h11, 14'h0000, 1'b1, "illegal_11");
    drive(1'b1, 6'h2A, 14'h0000, 1'b1, "illegal_2a");

    drive(1'b1, 6'h23, 14'h0C70, 1'b0, "lw");
    for (int i = 0; i < 3; i++) drive(1'b0, 6'h02, 14'h0C70, 1'b0, "lw_hold");

`ifdef CTRL_BYTE_MEM_EN
    drive(1'b1, 6'h24, 14'h2C70, 1'b0, "lbu");
    drive(1'b1, 6'h28, 14'h2C08, 1'b0, "sb");
`else
    drive(1'b1, 6'h24, 14'h0000, 1'b1, "lbu");
    drive(1'b1, 6'h28, 14'h0000, 1'b1, "sb");
`endif
    drive(1'b1, 6'h02, 14'h0001, 1'b0, "j_after");
    drive(1'b0, 6'h02, 14'h0001, 1'b0, "j_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
